// File: rtl/vga_sync_gen_if.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundles the link between the horizontal pixel counter and the sync
//   generator, together with the timing outputs the generator drives.
//
//   Signals:
//     iH_Enable    : one-cycle pulse from the H counter at h = 0 of a new line
//     iH_Count     : current horizontal count, 0..H_TOTAL-1
//     oV_Count     : vertical line counter (direct view of the register)
//     oHSync       : horizontal sync, registered
//     oVSync       : vertical sync, registered
//     oVideo_On    : visible-area flag, registered
//     oPixel_X     : visible column, registered (0 outside visible area)
//     oPixel_Y     : visible row, registered (0 outside visible area)
//     oLine_Start  : strobe on the first pixel of a visible line
//     oFrame_Start : strobe on the first pixel of a frame
//
//   Modports:
//     master : the horizontal-counter side (drives iH_*, observes outputs)
//     slave  : the sync generator
// ----------------------------------------------------------------------------
interface vga_sync_gen_if;
    logic       iH_Enable;
    logic [9:0] iH_Count;
    logic [9:0] oV_Count;
    logic       oHSync;
    logic       oVSync;
    logic       oVideo_On;
    logic [9:0] oPixel_X;
    logic [9:0] oPixel_Y;
    logic       oLine_Start;
    logic       oFrame_Start;

    modport master (
        output iH_Enable, iH_Count,
        input  oV_Count, oHSync, oVSync, oVideo_On,
        input  oPixel_X, oPixel_Y, oLine_Start, oFrame_Start
    );

    modport slave (
        input  iH_Enable, iH_Count,
        output oV_Count, oHSync, oVSync, oVideo_On,
        output oPixel_X, oPixel_Y, oLine_Start, oFrame_Start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
//   Vertical line counter and registered sync/video decode for the VGA core.
//   Sits behind the horizontal pixel counter: it takes the horizontal count
//   and the end-of-line enable pulse and produces HSYNC, VSYNC, video-active,
//   pixel coordinates and line/frame start strobes, all one cycle after the
//   horizontal count they belong to.
//
//   Ports:
//     iClk : pixel clock
//     iRst : asynchronous, active-high reset
//     bus  : vga_sync_gen_if.slave (iH_Enable/iH_Count in, timing out)
//
//   Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; H_TOTAL
//   must equal the wrap limit of the upstream horizontal counter.
// ----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic           iClk,
    input  logic           iRst,
    vga_sync_gen_if.slave  bus
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_VIS_L    = 10'(H_VISIBLE);
    localparam logic [9:0]  HS_START_L = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END_L   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_VIS_L    = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_START_L = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END_L   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]  V_LAST_L   = 10'(V_TOTAL - 1);
    // Eleven bits so that H_TOTAL = 1024 still compares correctly.
    localparam logic [10:0] H_TOT_L    = 11'(H_TOTAL);

    localparam logic HS_ACT = H_SYNC_POL;
    localparam logic VS_ACT = V_SYNC_POL;

    logic [9:0] r_vcnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    logic       r_line_start;
    logic       r_frame_start;

    logic [9:0] w_v_next;
    logic [9:0] w_v_eff;
    logic       w_h_valid;
    logic       w_h_vis;
    logic       w_v_vis;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_video;
    logic       w_h_zero;

    assign w_v_next = (r_vcnt == V_LAST_L) ? 10'd0 : r_vcnt + 10'd1;

    // The enable arrives together with h = 0 of the new line, so the decode
    // must already use the line number the counter is about to take.
    assign w_v_eff  = bus.iH_Enable ? w_v_next : r_vcnt;

    // Counts beyond the line length are blanking: no video, no sync, no strobe.
    assign w_h_valid = ({1'b0, bus.iH_Count} < H_TOT_L);
    assign w_h_vis   = w_h_valid && (bus.iH_Count < H_VIS_L);
    assign w_v_vis   = (w_v_eff < V_VIS_L);
    assign w_hs_act  = w_h_valid && (bus.iH_Count >= HS_START_L)
                                 && (bus.iH_Count <= HS_END_L);
    assign w_vs_act  = (w_v_eff >= VS_START_L) && (w_v_eff <= VS_END_L);
    assign w_video   = w_h_vis && w_v_vis;
    assign w_h_zero  = (bus.iH_Count == 10'd0);

    // NOTE: the reset is in the sensitivity list, so every register drops to
    // its reset value as soon as iRst rises, not at the next clock edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_vcnt        <= 10'd0;
            r_hsync       <= ~HS_ACT;
            r_vsync       <= ~VS_ACT;
            r_video_on    <= 1'b0;
            r_pixel_x     <= 10'd0;
            r_pixel_y     <= 10'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so vcnt and the decode stay in lockstep.
            if (bus.iH_Enable) begin
                r_vcnt <= w_v_next;
            end
            r_hsync       <= w_hs_act ? HS_ACT : ~HS_ACT;
            r_vsync       <= w_vs_act ? VS_ACT : ~VS_ACT;
            r_video_on    <= w_video;
            r_pixel_x     <= w_video ? bus.iH_Count : 10'd0;
            r_pixel_y     <= w_video ? w_v_eff : 10'd0;
            r_line_start  <= w_h_zero && w_v_vis;
            r_frame_start <= w_h_zero && (w_v_eff == 10'd0);
        end
    end

    assign bus.oV_Count     = r_vcnt;
    assign bus.oHSync       = r_hsync;
    assign bus.oVSync       = r_vsync;
    assign bus.oVideo_On    = r_video_on;
    assign bus.oPixel_X     = r_pixel_x;
    assign bus.oPixel_Y     = r_pixel_y;
    assign bus.oLine_Start  = r_line_start;
    assign bus.oFrame_Start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen. Two instances share the same stimulus:
//   one with default (active-low) sync polarity, one with both syncs
//   active-high. Inputs change 1 ns after a rising edge; outputs are sampled
//   at that same point, so each sample reflects the inputs of the previous
//   cycle.
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   v_model = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if bus();
    vga_sync_gen_if bus_p();

    assign bus_p.iH_Enable = bus.iH_Enable;
    assign bus_p.iH_Count  = bus.iH_Count;

    vga_sync_gen u_dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    vga_sync_gen #(
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b1)
    ) u_dut_pol (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_p.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic apply(input logic en, input logic [9:0] h);
        bus.iH_Enable = en;
        bus.iH_Count  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " hsync"},  32'(bus.oHSync),       32'd1);
        check({tag, " vsync"},  32'(bus.oVSync),       32'd1);
        check({tag, " video"},  32'(bus.oVideo_On),    32'd0);
        check({tag, " vcount"}, 32'(bus.oV_Count),     32'd0);
        check({tag, " px"},     32'(bus.oPixel_X),     32'd0);
        check({tag, " py"},     32'(bus.oPixel_Y),     32'd0);
        check({tag, " ls"},     32'(bus.oLine_Start),  32'd0);
        check({tag, " fs"},     32'(bus.oFrame_Start), 32'd0);
        check({tag, " hs_p"},   32'(bus_p.oHSync),     32'd0);
        check({tag, " vs_p"},   32'(bus_p.oVSync),     32'd0);
    endtask

    initial begin
        int hs_low, hs_p_high, vid_cnt, ls_cnt, fs_cnt, px_max, vs_low;

        rst           = 1'b1;
        bus.iH_Enable = 1'b0;
        bus.iH_Count  = 10'd0;

        // Held in reset with random inputs: nothing may move.
        for (int i = 0; i < 5; i++) begin
            bus.iH_Enable = 1'($urandom);
            bus.iH_Count  = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
            check_reset_state("rst_hold");
        end
        bus.iH_Enable = 1'b0;
        rst = 1'b0;

        // First pixel of the first frame.
        apply(1'b0, 10'd0);
        check("f0 fs",     32'(bus.oFrame_Start), 32'd1);
        check("f0 ls",     32'(bus.oLine_Start),  32'd1);
        check("f0 video",  32'(bus.oVideo_On),    32'd1);
        check("f0 px",     32'(bus.oPixel_X),     32'd0);
        check("f0 vcount", 32'(bus.oV_Count),     32'd0);
        check("f0 hsync",  32'(bus.oHSync),       32'd1);
        check("f0 hs_p",   32'(bus_p.oHSync),     32'd0);

        // Horizontal boundaries.
        apply(1'b0, 10'd639);
        check("h639 video", 32'(bus.oVideo_On),    32'd1);
        check("h639 px",    32'(bus.oPixel_X),     32'd639);
        check("h639 ls",    32'(bus.oLine_Start),  32'd0);
        check("h639 fs",    32'(bus.oFrame_Start), 32'd0);
        apply(1'b0, 10'd640);
        check("h640 video", 32'(bus.oVideo_On),    32'd0);
        check("h640 px",    32'(bus.oPixel_X),     32'd0);
        apply(1'b0, 10'd655);
        check("h655 hsync", 32'(bus.oHSync),       32'd1);
        apply(1'b0, 10'd656);
        check("h656 hsync", 32'(bus.oHSync),       32'd0);
        check("h656 hs_p",  32'(bus_p.oHSync),     32'd1);
        apply(1'b0, 10'd751);
        check("h751 hsync", 32'(bus.oHSync),       32'd0);
        apply(1'b0, 10'd752);
        check("h752 hsync", 32'(bus.oHSync),       32'd1);
        check("h752 hs_p",  32'(bus_p.oHSync),     32'd0);

        // Out-of-range horizontal counts are blanking.
        apply(1'b0, 10'd900);
        check("h900 video",  32'(bus.oVideo_On),    32'd0);
        check("h900 hsync",  32'(bus.oHSync),       32'd1);
        check("h900 hs_p",   32'(bus_p.oHSync),     32'd0);
        check("h900 ls",     32'(bus.oLine_Start),  32'd0);
        check("h900 fs",     32'(bus.oFrame_Start), 32'd0);
        check("h900 vcount", 32'(bus.oV_Count),     32'd0);
        apply(1'b0, 10'd1023);
        check("h1023 video", 32'(bus.oVideo_On),    32'd0);
        check("h1023 hsync", 32'(bus.oHSync),       32'd1);

        // One complete line 0..799 on line 0.
        hs_low = 0; hs_p_high = 0; vid_cnt = 0; ls_cnt = 0; fs_cnt = 0; px_max = 0;
        for (int h = 0; h < 800; h++) begin
            apply(1'b0, 10'(h));
            if (!bus.oHSync)   hs_low++;
            if (bus_p.oHSync)  hs_p_high++;
            if (bus.oVideo_On) vid_cnt++;
            if (bus.oLine_Start)  ls_cnt++;
            if (bus.oFrame_Start) fs_cnt++;
            if (int'(bus.oPixel_X) > px_max) px_max = int'(bus.oPixel_X);
        end
        check("line hs_low",    32'(hs_low),    32'd96);
        check("line hs_p_high", 32'(hs_p_high), 32'd96);
        check("line video",     32'(vid_cnt),   32'd640);
        check("line ls",        32'(ls_cnt),    32'd1);
        check("line fs",        32'(fs_cnt),    32'd1);
        check("line px_max",    32'(px_max),    32'd639);

        // Step through every line of a frame with back-to-back enables at h = 0,
        // ending on the wrap from line 524 back to line 0.
        vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        for (int n = 0; n < 525; n++) begin
            apply(1'b1, 10'd0);
            v_model = (v_model == 524) ? 0 : v_model + 1;
            check("step vcount", 32'(bus.oV_Count), 32'(v_model));
            if (!bus.oVSync)      vs_low++;
            if (bus.oLine_Start)  ls_cnt++;
            if (bus.oFrame_Start) fs_cnt++;
            case (v_model)
                1: begin
                    check("v1 py", 32'(bus.oPixel_Y),     32'd1);
                    check("v1 ls", 32'(bus.oLine_Start),  32'd1);
                    check("v1 fs", 32'(bus.oFrame_Start), 32'd0);
                end
                479: begin
                    check("v479 py",    32'(bus.oPixel_Y),    32'd479);
                    check("v479 ls",    32'(bus.oLine_Start), 32'd1);
                    check("v479 video", 32'(bus.oVideo_On),   32'd1);
                end
                480: begin
                    check("v480 video", 32'(bus.oVideo_On),   32'd0);
                    check("v480 ls",    32'(bus.oLine_Start), 32'd0);
                    check("v480 py",    32'(bus.oPixel_Y),    32'd0);
                    check("v480 vsync", 32'(bus.oVSync),      32'd1);
                end
                489: check("v489 vsync", 32'(bus.oVSync), 32'd1);
                490: begin
                    check("v490 vsync", 32'(bus.oVSync),   32'd0);
                    check("v490 vs_p",  32'(bus_p.oVSync), 32'd1);
                end
                491: check("v491 vsync", 32'(bus.oVSync), 32'd0);
                492: check("v492 vsync", 32'(bus.oVSync), 32'd1);
                524: begin
                    check("v524 vsync", 32'(bus.oVSync),    32'd1);
                    check("v524 video", 32'(bus.oVideo_On), 32'd0);
                end
                0: begin
                    check("wrap fs",    32'(bus.oFrame_Start), 32'd1);
                    check("wrap ls",    32'(bus.oLine_Start),  32'd1);
                    check("wrap vsync", 32'(bus.oVSync),       32'd1);
                    check("wrap vs_p",  32'(bus_p.oVSync),     32'd0);
                    check("wrap py",    32'(bus.oPixel_Y),     32'd0);
                    check("wrap video", 32'(bus.oVideo_On),    32'd1);
                end
                default: ;
            endcase
        end
        check("frame vs_low", 32'(vs_low), 32'd2);
        check("frame ls",     32'(ls_cnt), 32'd480);
        check("frame fs",     32'(fs_cnt), 32'd1);

        // Move to line 200, pixel 300, then reset between clock edges.
        for (int n = 0; n < 200; n++) begin
            apply(1'b1, 10'd0);
            v_model++;
        end
        apply(1'b0, 10'd300);
        check("mid vcount", 32'(bus.oV_Count),  32'd200);
        check("mid video",  32'(bus.oVideo_On), 32'd1);
        check("mid px",     32'(bus.oPixel_X),  32'd300);
        check("mid py",     32'(bus.oPixel_Y),  32'd200);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        v_model = 0;
        apply(1'b0, 10'd0);
        check("restart fs",     32'(bus.oFrame_Start), 32'd1);
        check("restart vcount", 32'(bus.oV_Count),     32'd0);
        check("restart py",     32'(bus.oPixel_Y),     32'd0);
        check("restart video",  32'(bus.oVideo_On),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
